// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame layout
// constants and the loader FSM state type.
package imem_boot_loader_pkg;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned CNT_W          = 8 * HDR_BYTES;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects payload bytes LSB-first into one imem word and pulses word_valid_o
// for one cycle, aligned with the registered word, after the last byte.
module word_assembler
   import imem_boot_loader_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   input  logic                          byte_valid_i,
   input  logic [7:0]                    byte_i,
   output logic                          last_o,
   output logic                          word_valid_o,
   output logic [BYTES_PER_WORD*8-1:0]   word_o
);

   localparam int unsigned SH_W = (BYTES_PER_WORD - 1) * 8;

   logic [1:0]                  byte_idx_q;
   logic [SH_W-1:0]             sh_q;
   logic [BYTES_PER_WORD*8-1:0] word_q;
   logic                        valid_q;

   assign last_o       = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
   assign word_valid_o = valid_q;
   assign word_o       = word_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q <= '0;
         sh_q       <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (clr_i) begin
            byte_idx_q <= '0;
         end else if (byte_valid_i) begin
            if (last_o) begin
               word_q     <= {byte_i, sh_q};
               valid_q    <= 1'b1;
               byte_idx_q <= '0;
            end else begin
               sh_q       <= {byte_i, sh_q[SH_W-1:8]};
               byte_idx_q <= byte_idx_q + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads the instruction memory from a framed byte stream (count, payload,
// XOR checksum) and holds the core in reset until a verified image is present.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

   boot_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, widx_q, n_hdr;
   logic [7:0]        csum_q;
   logic [ADDR_W-1:0] addr_q;
   logic              in_ready_q, core_rst_q, done_q, err_q;
   logic              xfer, reload_ok, asm_valid, asm_last, word_done;
   logic [BYTES_PER_WORD*8-1:0] asm_word;

   assign xfer      = in_valid & in_ready_q;
   assign reload_ok = reload & ((state_q == DONE) | (state_q == ERROR));
   assign word_done = xfer & (state_q == DATA) & asm_last;
   assign n_hdr     = {in_data, cnt_q[7:0]};

   word_assembler u_asm (
      .clk          (clk),
      .rst_n        (rst),
      .clr_i        (reload_ok),
      .byte_valid_i (xfer & (state_q == DATA)),
      .byte_i       (in_data),
      .last_o       (asm_last),
      .word_valid_o (asm_valid),
      .word_o       (asm_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR_LO: if (xfer) state_d = HDR_HI;
         HDR_HI: if (xfer) begin
            if (32'(n_hdr) > MAX_WORDS) state_d = ERROR;
            else if (n_hdr == '0)       state_d = CSUM;
            else                        state_d = DATA;
         end
         DATA:   if (word_done && (widx_q == cnt_q - CNT_W'(1))) state_d = CSUM;
         CSUM:   if (xfer) state_d = (in_data == csum_q) ? DONE : ERROR;
         DONE, ERROR: if (reload) state_d = HDR_LO;
         default: state_d = HDR_LO;
      endcase
   end

   // Status outputs are registered from the next state so they track the
   // state register on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= HDR_LO;
         in_ready_q <= 1'b0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         widx_q     <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d inside {HDR_LO, HDR_HI, DATA, CSUM});
         core_rst_q <= (state_d != DONE);
         done_q     <= (state_d == DONE);
         err_q      <= (state_d == ERROR);
         if (reload_ok) begin
            cnt_q  <= '0;
            widx_q <= '0;
            csum_q <= '0;
            addr_q <= '0;
         end else if (xfer) begin
            case (state_q)
               HDR_LO: cnt_q[7:0]  <= in_data;
               HDR_HI: cnt_q[15:8] <= in_data;
               DATA: begin
                  csum_q <= csum_q ^ in_data;
                  if (asm_last) begin
                     addr_q <= widx_q[ADDR_W-1:0];
                     widx_q <= widx_q + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = asm_valid;
   assign imem_addr  = addr_q;
   assign imem_wdata = asm_word;
   assign core_rst   = core_rst_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule
